// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder: word RAM, free-running timer and console TX FIFO      |
// | behind a zero-latency memory-mapped CPU port.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_responder #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        MemWrite,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_hit
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FIFO_FULL = FIFO_DEPTH[PW:0];

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [31:0]   cnt_q, cnt_d, cmp_q, cmp_d;
  logic          hit_q, hit_d, ovf_q, ovf_d, bad_q, bad_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic ram_sel, io_sel, cnt_sel, cmp_sel, con_sel, stat_sel, unmapped;
  logic stat_wr, push, pop, push_ok, full;
  logic [7:0]  count8;
  logic [31:0] status_word;
  logic        unused_adr;

  assign unused_adr = ^adr[1:0];

  // Address decode; RAM indices past RAM_WORDS fall into the unmapped space.
  always_comb begin
    ram_sel  = (adr[31:AW+2] == '0);
    io_sel   = (adr[31:4] == 28'hFFFF_000);
    cnt_sel  = io_sel && (adr[3:2] == 2'd0);
    cmp_sel  = io_sel && (adr[3:2] == 2'd1);
    con_sel  = io_sel && (adr[3:2] == 2'd2);
    stat_sel = io_sel && (adr[3:2] == 2'd3);
    unmapped = !ram_sel && !io_sel;
  end

  assign tx_valid  = (count_q != '0);
  assign tx_data   = fifo_mem[rd_ptr_q];
  assign timer_hit = hit_q;

  always_comb begin
    full    = (count_q == FIFO_FULL);
    stat_wr = MemWrite && stat_sel;
    push    = MemWrite && con_sel;
    pop     = tx_valid && tx_ready;
    push_ok = push && (!full || pop);

    count8          = '0;
    count8[PW:0]    = count_q;
    status_word     = {16'b0, count8, 4'b0, bad_q, ovf_q, full, hit_q};

    cnt_d = (MemWrite && cnt_sel) ? writedata : cnt_q + 32'd1;
    cmp_d = (MemWrite && cmp_sel) ? writedata : cmp_q;

    // Set conditions take priority over software clears.
    hit_d = (cnt_q == cmp_q) ? 1'b1 : (stat_wr && writedata[0]) ? 1'b0 : hit_q;
    ovf_d = (push && full && !pop) ? 1'b1 : (stat_wr && writedata[2]) ? 1'b0 : ovf_q;
    bad_d = (MemWrite && unmapped) ? 1'b1 : (stat_wr && writedata[3]) ? 1'b0 : bad_q;

    rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    readdata = '0;
    if (ram_sel)       readdata = ram[adr[AW+1:2]];
    else if (cnt_sel)  readdata = cnt_q;
    else if (cmp_sel)  readdata = cmp_q;
    else if (stat_sel) readdata = status_word;
  end

  // Storage arrays carry no reset; RAM contents survive rst.
  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel && !rst) ram[adr[AW+1:2]] <= writedata;
    if (push_ok) fifo_mem[wr_ptr_q] <= writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      cmp_q    <= '1;
      hit_q    <= 1'b0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      hit_q    <= hit_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// Directed testbench for mem_responder with hand-computed expectations.
module tb_mem_responder;

  localparam logic [31:0] A_CNT  = 32'hFFFF_0000;
  localparam logic [31:0] A_CMP  = 32'hFFFF_0004;
  localparam logic [31:0] A_CON  = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] writedata = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        timer_hit;

  integer tests = 0;
  integer fails = 0;

  mem_responder dut (
    .clk(clk), .rst(rst), .adr(adr), .writedata(writedata), .MemWrite(MemWrite),
    .readdata(readdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .timer_hit(timer_hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adr = a; writedata = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    adr = a; MemWrite = 1'b0;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    tick(); tick();
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    tests++; if (timer_hit !== 1'b0) begin fails++; $display("FAIL reset_timer_hit got %b want 0", timer_hit); end
    rd(A_CNT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_cnt got %h want 0", v); end
    rd(A_CMP, v);
    tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_cmp got %h want ffffffff", v); end
    rd(A_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_status got %h want 0", v); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ram();
    logic [31:0] v;
    wr(32'h44, 32'h1234_5678);
    wr(32'h40, 32'hDEAD_BEEF);
    rd(32'h40, v);
    tests++; if (v !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_40 got %h want deadbeef", v); end
    rd(32'h43, v);
    tests++; if (v !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_43 got %h want deadbeef", v); end
    rd(32'h44, v);
    tests++; if (v !== 32'h1234_5678) begin fails++; $display("FAIL ram_44 got %h want 12345678", v); end
    wr(32'hFFC, 32'h0BAD_F00D);
    rd(32'hFFC, v);
    tests++; if (v !== 32'h0BAD_F00D) begin fails++; $display("FAIL ram_top got %h want 0badf00d", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) wr(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      rd(32'h100 + 32'(4 * i), v);
      tests++; if (v !== 32'hA000_0000 + 32'(i)) begin fails++; $display("FAIL b2b_word%0d got %h want %h", i, v, 32'hA000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_timer_count();
    logic [31:0] v, w;
    rd(A_CNT, v);
    tick();
    rd(A_CNT, w);
    tests++; if (w !== v + 32'd1) begin fails++; $display("FAIL cnt_incr got %h want %h", w, v + 32'd1); end
    wr(A_CNT, 32'hFFFF_FFFF);
    rd(A_CNT, v);
    tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL cnt_load got %h want ffffffff", v); end
    tick();
    rd(A_CNT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL cnt_wrap got %h want 0", v); end
    // Counter equalled the reset compare value on that edge.
    tests++; if (timer_hit !== 1'b1) begin fails++; $display("FAIL hit_at_ffffffff got %b want 1", timer_hit); end
  endtask

  task automatic test_timer_hit();
    logic [31:0] v;
    wr(A_CNT, 32'd100);
    wr(A_STAT, 32'h1);
    wr(A_CMP, 32'd5);
    wr(A_CNT, 32'd0);
    for (int i = 0; i <= 5; i++) begin
      rd(A_CNT, v);
      tests++; if (v !== 32'(i) || timer_hit !== 1'b0) begin fails++; $display("FAIL hit_early cnt %h hit %b want cnt %h hit 0", v, timer_hit, 32'(i)); end
      tick();
    end
    rd(A_CNT, v);
    tests++; if (v !== 32'd6 || timer_hit !== 1'b1) begin fails++; $display("FAIL hit_rise cnt %h hit %b want cnt 6 hit 1", v, timer_hit); end
    tick(); tick(); tick();
    tests++; if (timer_hit !== 1'b1) begin fails++; $display("FAIL hit_sticky got %b want 1", timer_hit); end
    wr(A_STAT, 32'h1);
    tests++; if (timer_hit !== 1'b0) begin fails++; $display("FAIL hit_clear got %b want 0", timer_hit); end
    wr(A_CNT, 32'd5);
    wr(A_STAT, 32'h1);
    tests++; if (timer_hit !== 1'b1) begin fails++; $display("FAIL hit_set_wins got %b want 1", timer_hit); end
    wr(A_STAT, 32'h1);
    tests++; if (timer_hit !== 1'b0) begin fails++; $display("FAIL hit_clear2 got %b want 0", timer_hit); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(A_CON, 32'h41 + 32'(i));
    rd(A_STAT, v);
    tests++; if (v !== 32'h0000_0806) begin fails++; $display("FAIL ovf_status got %h want 00000806", v); end
    rd(A_CON, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL con_read got %h want 0", v); end
    tick();
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin fails++; $display("FAIL tx_hold valid %b data %h want 1 41", tx_valid, tx_data); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin fails++; $display("FAIL ovf_drain%0d valid %b data %h want 1 %h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b want 0", tx_valid); end
    wr(A_STAT, 32'h4);
    rd(A_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL ovf_clear got %h want 0", v); end
  endtask

  task automatic test_fifo_full_pushpop();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_CON, 32'h41 + 32'(i));
    tx_ready = 1'b1;
    wr(A_CON, 32'h5A);
    tx_ready = 1'b0;
    rd(A_STAT, v);
    tests++; if (v !== 32'h0000_0802) begin fails++; $display("FAIL fullpp_status got %h want 00000802", v); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = (i == 7) ? 8'h5A : 8'(8'h42 + i);
      tests++; if (tx_valid !== 1'b1 || tx_data !== e) begin fails++; $display("FAIL fullpp_drain%0d valid %b data %h want 1 %h", i, tx_valid, tx_data, e); end
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL fullpp_empty got %b want 0", tx_valid); end
  endtask

  task automatic test_fifo_empty_pushpop();
    logic [31:0] v;
    adr = A_CON; writedata = 32'h77; MemWrite = 1'b1; tx_ready = 1'b1;
    #1;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL no_bypass got %b want 0", tx_valid); end
    tick();
    MemWrite = 1'b0; tx_ready = 1'b0;
    tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin fails++; $display("FAIL emptypp valid %b data %h want 1 77", tx_valid, tx_data); end
    rd(A_STAT, v);
    tests++; if (v !== 32'h0000_0100) begin fails++; $display("FAIL emptypp_status got %h want 00000100", v); end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL emptypp_drain got %b want 0", tx_valid); end
  endtask

  task automatic test_badacc();
    logic [31:0] v;
    rd(32'h8000_0004, v);
    tick();
    rd(A_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL bad_read_only got %h want 0", v); end
    wr(32'h0, 32'h1111_1111);
    wr(32'h8000_0000, 32'hCAFE_BABE);
    rd(32'h8000_0000, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL bad_unmapped_read got %h want 0", v); end
    rd(32'h40, v);
    tests++; if (v !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bad_ram_intact got %h want deadbeef", v); end
    rd(A_STAT, v);
    tests++; if (v !== 32'h8) begin fails++; $display("FAIL bad_status got %h want 8", v); end
    wr(A_STAT, 32'h8);
    rd(A_STAT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL bad_clear got %h want 0", v); end
    wr(32'h1000, 32'h2222_2222);
    rd(32'h0, v);
    tests++; if (v !== 32'h1111_1111) begin fails++; $display("FAIL bad_ram_alias got %h want 11111111", v); end
    rd(A_STAT, v);
    tests++; if (v !== 32'h8) begin fails++; $display("FAIL bad_oob_status got %h want 8", v); end
    rd(32'hFFFF_0010, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL bad_io_read got %h want 0", v); end
    wr(A_STAT, 32'h8);
  endtask

  task automatic test_reset_midstream();
    logic [31:0] v;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_CON, 32'h61 + 32'(i));
    wr(A_CNT, 32'h1234);
    rd(A_CNT, v);
    tests++; if (v !== 32'h1234) begin fails++; $display("FAIL mid_cnt_load got %h want 1234", v); end
    rst = 1'b1; adr = A_CNT; writedata = 32'h5555; MemWrite = 1'b1; tx_ready = 1'b1;
    tick();
    MemWrite = 1'b0; tx_ready = 1'b0;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL mid_tx_valid got %b want 0", tx_valid); end
    rd(A_CNT, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL mid_cnt got %h want 0", v); end
    rd(32'h40, v);
    tests++; if (v !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mid_ram got %h want deadbeef", v); end
    rst = 1'b0;
    tick();
    rd(A_CNT, v);
    tests++; if (v !== 32'h1) begin fails++; $display("FAIL mid_cnt_run got %h want 1", v); end
    rd(A_STAT, v);
    tests++; if (v !== 32'h0 || tx_valid !== 1'b0) begin fails++; $display("FAIL mid_status got %h valid %b want 0 0", v, tx_valid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram();
    test_back_to_back();
    test_timer_count();
    test_timer_hit();
    test_fifo_overflow();
    test_fifo_full_pushpop();
    test_fifo_empty_pushpop();
    test_badacc();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024, SHALL set the word-RAM depth (power of two, 4 KB at default).
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the console FIFO depth (power of two, >=2).
REQ-003 Port clk, input, 1: SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: SHALL be the synchronous, active-high reset.
REQ-005 Port adr, input, 32: SHALL carry the byte address from the CPU; adr[1:0] SHALL be ignored.
REQ-006 Port writedata, input, 32: SHALL carry the store data from the CPU.
REQ-007 Port MemWrite, input, 1: SHALL be the write strobe; a write commits at the next rising edge.
REQ-008 Port readdata, output, 32: SHALL carry the combinational read data for adr.
REQ-009 Port tx_data, output, 8: SHALL carry the console FIFO head byte.
REQ-010 Port tx_valid, output, 1: SHALL be high whenever the FIFO is non-empty.
REQ-011 Port tx_ready, input, 1: SHALL pop the head byte at a rising edge when tx_valid and tx_ready are both high.
REQ-012 Port timer_hit, output, 1: SHALL be the sticky timer-compare flag.

Function
REQ-013 The address map SHALL be: 0x0000_0000 to 4*RAM_WORDS-1 RAM; 0xFFFF_0000 TIMER_CNT; 0xFFFF_0004 TIMER_CMP; 0xFFFF_0008 CON_DATA; 0xFFFF_000C STATUS; everything else unmapped.
REQ-014 Reads SHALL be purely combinational with zero-cycle latency, because the CPU latches readdata in the same cycle.
REQ-015 A RAM write SHALL store writedata at word index adr[log2(RAM_WORDS)+1:2], and a read in the following cycle SHALL return the new value.
REQ-016 TIMER_CNT SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0.
REQ-017 A write to TIMER_CNT SHALL load writedata, with no increment that cycle.
REQ-018 TIMER_CMP SHALL be read/write; timer_hit SHALL set in the cycle after the pre-edge TIMER_CNT equals TIMER_CMP.
REQ-019 A write to STATUS with writedata[0]=1 SHALL clear timer_hit, and set SHALL win over a simultaneous clear.
REQ-020 A write to CON_DATA SHALL push writedata[7:0] into the FIFO, and a CON_DATA read SHALL return 0.
REQ-021 A push while the FIFO is full and no pop occurs that edge SHALL drop the byte and set the sticky overflow flag.
REQ-022 A push while the FIFO is full with a simultaneous pop SHALL be accepted, and the count SHALL be unchanged.
REQ-023 A simultaneous push and pop on an empty FIFO SHALL perform no pop (tx_valid low), and the push SHALL be accepted.
REQ-024 There SHALL be no bypass: a pushed byte SHALL appear on tx_data/tx_valid no earlier than the next cycle.
REQ-025 The FIFO SHALL use wrapping read/write pointers plus a count of width log2(FIFO_DEPTH)+1.
REQ-026 A STATUS read SHALL return {16'b0, count[7:0] zero-extended, 4'b0, badacc, overflow, full, timer_hit} with timer_hit at bit 0.
REQ-027 A write to STATUS with writedata[2]=1 SHALL clear overflow, and writedata[3]=1 SHALL clear badacc.
REQ-028 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored and SHALL set the sticky badacc flag.
REQ-029 Unmapped accesses, including RAM indices >= RAM_WORDS, SHALL set badacc only when MemWrite is high.
REQ-030 tx_data SHALL hold its value while tx_valid is high and tx_ready is low.

Reset
REQ-031 Under rst, TIMER_CNT SHALL become 0, TIMER_CMP 0xFFFF_FFFF, the FIFO empty (tx_valid=0), and timer_hit, overflow and badacc 0.
REQ-032 rst SHALL take priority over any simultaneous write or pop.
REQ-033 RAM contents SHALL be unaffected by rst.
REQ-034 rst asserted mid-stream SHALL discard all FIFO contents, and tx_valid SHALL be 0 in the cycle after the reset edge.

Verification
REQ-035 Write 0xDEADBEEF to 0x40, then read 0x40 and 0x43 -> both reads return 0xDEADBEEF; read 0x44 -> previous contents.
REQ-036 Write TIMER_CMP=5 after reset -> timer_hit rises the cycle after TIMER_CNT==5 and stays set; STATUS write 0x1 clears it.
REQ-037 tx_ready=0, push 9 bytes 0x41..0x49 with FIFO_DEPTH=8 -> STATUS full=1, overflow=1, count=8; draining yields 0x41..0x48 in order.
REQ-038 FIFO full with tx_ready=1 and a same-cycle push of 0x5A -> count stays 8, overflow stays 0, 0x5A is drained last.
REQ-039 Write to 0x8000_0000 -> RAM unchanged, badacc=1; read 0x8000_0000 -> 0; STATUS write 0x8 clears badacc.
REQ-040 Assert rst with 3 bytes queued and TIMER_CNT=0x1234 -> next cycle tx_valid=0, TIMER_CNT=0, RAM word 0x40 still 0xDEADBEEF.
